// File: rtl/f1_start_ctrl.sv
// F1 race-start sequencer: lamp build-up, random hold,
// reaction timer and false-start detection.
module f1_start_ctrl #(
  parameter int WIDTH   = 16,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trigger,
  input  logic               react,
  input  logic [WIDTH-1:0]   N,
  output logic [D_WIDTH-1:0] out,
  output logic               busy,
  output logic               time_valid,
  output logic               false_start,
  output logic [15:0]        react_time
);
  typedef enum logic [2:0] {
    IDLE, LIGHTS, HOLD, GO, DONE
  } state_t;

  localparam logic [D_WIDTH-1:0] ONES = '1;
  localparam logic [D_WIDTH-1:0] ONE  = D_WIDTH'(1);

  state_t             state, state_n;
  logic [WIDTH-1:0]   cnt, cnt_n;
  logic [D_WIDTH-1:0] out_n;
  logic [6:0]         lfsr, dly, dly_n;
  logic [15:0]        rcnt, rcnt_n, rt_n;
  logic               tv_n, fs_n, tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out         <= '0;
      cnt         <= N;
      dly         <= '0;
      rcnt        <= '0;
      lfsr        <= 7'h01;
      react_time  <= '0;
      time_valid  <= 1'b0;
      false_start <= 1'b0;
    end else begin
      state       <= state_n;
      out         <= out_n;
      cnt         <= cnt_n;
      dly         <= dly_n;
      rcnt        <= rcnt_n;
      lfsr        <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      react_time  <= rt_n;
      time_valid  <= tv_n;
      false_start <= fs_n;
    end
  end

  assign tick = (cnt == '0);
  assign busy = (state == LIGHTS) ||
                (state == HOLD)   ||
                (state == GO);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    out_n   = out;
    dly_n   = dly;
    rcnt_n  = rcnt;
    rt_n    = react_time;
    tv_n    = time_valid;
    fs_n    = false_start;
    unique case (state)
      IDLE: begin
        out_n = '0;
        cnt_n = N;
        if (trigger) begin
          state_n = LIGHTS;
          out_n   = ONE;
        end
      end
      LIGHTS, HOLD: begin
        cnt_n = tick ? N : cnt - WIDTH'(1);
        // an early press beats any tick in the same cycle
        if (react) begin
          state_n = DONE;
          out_n   = '0;
          fs_n    = 1'b1;
          tv_n    = 1'b0;
        end else if (tick && state == LIGHTS) begin
          if (out == ONES) begin
            state_n = HOLD;
            dly_n   = lfsr;
          end else begin
            out_n = {out[D_WIDTH-2:0], 1'b1};
          end
        end else if (tick) begin
          if (dly == 7'd1) begin
            state_n = GO;
            out_n   = '0;
            rcnt_n  = '0;
          end else begin
            dly_n = dly - 7'd1;
          end
        end
      end
      GO: begin
        out_n = '0;
        if (rcnt != 16'hFFFF)
          rcnt_n = rcnt + 16'd1;
        if (react) begin
          state_n = DONE;
          rt_n    = rcnt;
          tv_n    = 1'b1;
          fs_n    = 1'b0;
        end
      end
      DONE: begin
        out_n = '0;
        cnt_n = N;
        if (trigger) begin
          state_n = LIGHTS;
          out_n   = ONE;
          tv_n    = 1'b0;
          fs_n    = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        out_n   = '0;
      end
    endcase
    // prescaler restarts a full period on every state change
    if (state_n != state)
      cnt_n = N;
  end
endmodule

// File: tb/tb_f1_start_ctrl.sv
// Bench for f1_start_ctrl: directed + randomized starts
// checked against a timing-formula reference model.
`timescale 1ns/1ps
module tb_f1_start_ctrl;
  logic        clk = 1'b0;
  logic        rst, trigger, react;
  logic [15:0] N;
  logic [7:0]  out;
  logic        busy, time_valid, false_start;
  logic [15:0] react_time;

  int          tests = 0;
  int          fails = 0;
  int          ph = 0;
  logic [6:0]  seq [127];
  logic [15:0] last_rt;
  bit          seen [128];

  f1_start_ctrl #(.WIDTH(16), .D_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .trigger(trigger),
    .react(react), .N(N), .out(out), .busy(busy),
    .time_valid(time_valid),
    .false_start(false_start),
    .react_time(react_time)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  // ph = edges since the last reset edge
  task automatic tick();
    @(posedge clk);
    if (rst) ph = 0;
    else ph = ph + 1;
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expo(input int t,
                                      input int n,
                                      input int g);
    int l;
    if (t >= g) return 8'h00;
    l = t / (n + 1) + 1;
    if (l > 8) l = 8;
    return 8'((1 << l) - 1);
  endfunction

  // hold length for a start whose trigger edge was at ph
  function automatic int hold_d(input int n);
    return int'(seq[(ph + 8 * (n + 1) - 1) % 127]);
  endfunction

  task automatic run(input int n, input int r,
                     input bit keep);
    int d, g;
    N = 16'(n);
    trigger = 1'b1;
    tick();
    if (!keep) trigger = 1'b0;
    d = hold_d(n);
    g = (8 + d) * (n + 1);
    chk("start_out", out, 8'h01);
    chk("start_busy", busy, 1);
    chk("start_tv", time_valid, 0);
    chk("start_fs", false_start, 0);
    for (int t = 1; t <= g; t++) begin
      tick();
      chk("seq_out", out, expo(t, n, g));
      chk("seq_busy", busy, 1);
    end
    for (int i = 1; i < r; i++) begin
      tick();
      chk("go_out", out, 8'h00);
    end
    react = 1'b1;
    tick();
    react = 1'b0;
    last_rt = (r - 1 > 65535) ? 16'hFFFF : 16'(r - 1);
    chk("rt_value", react_time, last_rt);
    chk("rt_tv", time_valid, 1);
    chk("rt_fs", false_start, 0);
    chk("rt_busy", busy, 0);
    chk("rt_out", out, 8'h00);
  endtask

  // tf<=0 or beyond GO: press on the final hold tick
  task automatic fstart(input int n, input int tf);
    int d, g, tfs;
    N = 16'(n);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    d = hold_d(n);
    g = (8 + d) * (n + 1);
    tfs = (tf <= 0 || tf > g) ? g : tf;
    chk("fs_start", out, 8'h01);
    for (int t = 1; t < tfs; t++) begin
      tick();
      chk("fs_pre_out", out, expo(t, n, g));
    end
    react = 1'b1;
    tick();
    react = 1'b0;
    chk("fs_out", out, 8'h00);
    chk("fs_flag", false_start, 1);
    chk("fs_tv", time_valid, 0);
    chk("fs_rt", react_time, last_rt);
    chk("fs_busy", busy, 0);
    repeat (3) begin
      tick();
      chk("fs_hold_out", out, 8'h00);
      chk("fs_hold_flag", false_start, 1);
      chk("fs_hold_busy", busy, 0);
    end
  endtask

  initial begin
    int cov, dexp, dobs, t;
    rst = 1'b1;
    trigger = 1'b0;
    react = 1'b0;
    N = 16'd3;
    last_rt = '0;
    seq[0] = 7'h01;
    for (int j = 1; j < 127; j++)
      seq[j] = {seq[j-1][5:0], seq[j-1][6] ^ seq[j-1][5]};

    tick();
    chk("rst_out", out, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_tv", time_valid, 0);
    chk("rst_fs", false_start, 0);
    chk("rst_rt", react_time, 16'h0000);
    rst = 1'b0;

    run(3, 10, 1'b0);
    fstart(3, 14);
    fstart(3, 0);

    N = 16'd3;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (34) tick();
    chk("hold_out", out, 8'hFF);
    chk("hold_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out", out, 8'h00);
    chk("midrst_busy", busy, 0);
    chk("midrst_tv", time_valid, 0);
    chk("midrst_fs", false_start, 0);
    chk("midrst_rt", react_time, 16'h0000);
    last_rt = '0;
    run(3, int'($urandom_range(1, 40)), 1'b0);

    repeat (8) begin
      if ($urandom_range(0, 1) == 1)
        run(int'($urandom_range(0, 3)),
            int'($urandom_range(1, 40)), 1'b0);
      else
        fstart(int'($urandom_range(0, 3)),
               int'($urandom_range(1, 60)));
    end

    run(0, 65540, 1'b1);
    run(0, 3, 1'b0);

    for (int k = 0; k < 127; k++) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (k) tick();
      N = 16'd0;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      dexp = hold_d(0);
      t = 0;
      while (out !== 8'h00 && t < 300) begin
        tick();
        t++;
      end
      dobs = t - 8;
      chk("lfsr_d", dobs, dexp);
      if (dobs >= 0 && dobs < 128) seen[dobs] = 1'b1;
      react = 1'b1;
      tick();
      react = 1'b0;
    end
    cov = 0;
    for (int j = 1; j < 128; j++)
      if (seen[j]) cov++;
    chk("lfsr_cover", cov, 127);
    chk("lfsr_zero", seen[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
